// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream_demux 1-to-2 stream demultiplexer.
// Provides the channel-select encoding, the default parameter values and
// the encoding of the one-entry output stage state.
package stream_demux_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_state_t;

endpackage

// File: rtl/stream_demux_stage.sv
// One-entry registered valid/ready output stage.
// The stage reports through load_en whether it can take a new word this
// cycle: it can when empty, or when full and the consumer is accepting the
// held word in the same cycle. The parent decides whether to actually load.
module stream_demux_stage
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    stage_state_t     state_q;
    stage_state_t     state_d;
    logic [WIDTH-1:0] data_q;

    // State register; a reset discards any held word without a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Data register only changes when a new word is loaded, which keeps the
    // output stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= load_data;
        end
    end

    // Next state and load capability; a load wins over a drain so that a
    // simultaneous drain-and-load keeps the stage full.
    always_comb begin
        state_d = state_q;
        load_en = (state_q == EMPTY) || out_ready;
        if (load) begin
            state_d = FULL;
        end else if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
        end
    end

    assign out_data  = data_q;
    assign out_valid = (state_q == FULL);

endmodule

// File: rtl/stream_demux.sv
// Sequential 1-to-2 stream demultiplexer.
// Each input word is steered by in_sel to channel A (0) or B (1), each with
// its own registered one-entry stage, so a stall on one channel never blocks
// words headed for the other. in_ready reflects only the selected stage.
// Optional feature: define STREAM_DEMUX_CNT_EN to add per-channel counters
// cnt_a/cnt_b of completed output transfers (CNT_W bits, wrapping).
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
`ifdef STREAM_DEMUX_CNT_EN
    , parameter int CNT_W = DEFAULT_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready
`ifdef STREAM_DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
`endif
);

    logic a_load_en;
    logic b_load_en;
    logic a_load;
    logic b_load;

    // Steering: the input handshake completes only against the stage chosen
    // by in_sel, and only that stage loads.
    always_comb begin
        in_ready = (in_sel == SEL_B) ? b_load_en : a_load_en;
        a_load   = in_valid && (in_sel == SEL_A) && a_load_en;
        b_load   = in_valid && (in_sel == SEL_B) && b_load_en;
    end

    stream_demux_stage #(
        .WIDTH(WIDTH)
    ) u_stage_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (a_load),
        .load_data (in_data),
        .load_en   (a_load_en),
        .out_data  (a_data),
        .out_valid (a_valid),
        .out_ready (a_ready)
    );

    stream_demux_stage #(
        .WIDTH(WIDTH)
    ) u_stage_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (b_load),
        .load_data (in_data),
        .load_en   (b_load_en),
        .out_data  (b_data),
        .out_valid (b_valid),
        .out_ready (b_ready)
    );

`ifdef STREAM_DEMUX_CNT_EN
    // Count completed output transfers per channel; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (a_valid && a_ready) begin
                cnt_a <= cnt_a + 1'b1;
            end
            if (b_valid && b_ready) begin
                cnt_b <= cnt_b + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Directed self-checking bench for stream_demux.
// Inputs change 1 time unit after a rising edge; outputs are sampled there
// too, and in_ready is sampled after the new inputs have settled.
module tb_stream_demux;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
`ifdef STREAM_DEMUX_CNT_EN
    localparam int CNT_W = 4;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
`endif

    int errors = 0;
    int checks = 0;

    stream_demux #(
        .WIDTH(WIDTH)
`ifdef STREAM_DEMUX_CNT_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready)
`ifdef STREAM_DEMUX_CNT_EN
        ,
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic s, input logic [WIDTH-1:0] d,
                                 input logic ar, input logic br);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'hAA, 1'b1, 1'b1);

        // Reset held while clocking with a valid input
        repeat (3) tick();
        checkOutput("rst_a_valid", {15'd0, a_valid}, 16'd0);
        checkOutput("rst_b_valid", {15'd0, b_valid}, 16'd0);
        checkOutput("rst_a_data", {8'd0, a_data}, 16'd0);
        checkOutput("rst_b_data", {8'd0, b_data}, 16'd0);
        checkOutput("rst_in_ready", {15'd0, in_ready}, 16'd1);
`ifdef STREAM_DEMUX_CNT_EN
        checkOutput("rst_cnt_a", {12'd0, cnt_a}, 16'd0);
`endif
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("post_rst_in_ready", {15'd0, in_ready}, 16'd1);

        // Steering to A then B, each valid lasting a single cycle
        applyStimulus(1'b1, 1'b0, 8'h11, 1'b1, 1'b1);
        checkOutput("steer_a_in_ready", {15'd0, in_ready}, 16'd1);
        tick();
        checkOutput("steer_a_valid", {15'd0, a_valid}, 16'd1);
        checkOutput("steer_a_data", {8'd0, a_data}, 16'h11);
        checkOutput("steer_a_b_idle", {15'd0, b_valid}, 16'd0);
        applyStimulus(1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
        checkOutput("steer_b_in_ready", {15'd0, in_ready}, 16'd1);
        tick();
        checkOutput("steer_a_drained", {15'd0, a_valid}, 16'd0);
        checkOutput("steer_b_valid", {15'd0, b_valid}, 16'd1);
        checkOutput("steer_b_data", {8'd0, b_data}, 16'h22);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        checkOutput("steer_b_drained", {15'd0, b_valid}, 16'd0);

        // Back-pressure on A, isolation of B
        applyStimulus(1'b1, 1'b0, 8'h33, 1'b0, 1'b1);
        checkOutput("bp_33_in_ready", {15'd0, in_ready}, 16'd1);
        tick();
        checkOutput("bp_a_33_valid", {15'd0, a_valid}, 16'd1);
        checkOutput("bp_a_33_data", {8'd0, a_data}, 16'h33);
        applyStimulus(1'b1, 1'b0, 8'h44, 1'b0, 1'b1);
        checkOutput("bp_44_blocked", {15'd0, in_ready}, 16'd0);
        tick();
        checkOutput("bp_a_hold_data", {8'd0, a_data}, 16'h33);
        checkOutput("bp_a_hold_valid", {15'd0, a_valid}, 16'd1);
        checkOutput("bp_44_still_blocked", {15'd0, in_ready}, 16'd0);
        applyStimulus(1'b1, 1'b0, 8'h44, 1'b1, 1'b1);
        checkOutput("bp_44_replace_ready", {15'd0, in_ready}, 16'd1);
        tick();
        checkOutput("bp_a_44_data", {8'd0, a_data}, 16'h44);
        checkOutput("bp_a_44_valid", {15'd0, a_valid}, 16'd1);
        applyStimulus(1'b1, 1'b1, 8'h55, 1'b0, 1'b1);
        checkOutput("iso_55_in_ready", {15'd0, in_ready}, 16'd1);
        tick();
        checkOutput("iso_b_55_valid", {15'd0, b_valid}, 16'd1);
        checkOutput("iso_b_55_data", {8'd0, b_data}, 16'h55);
        checkOutput("iso_a_still_44", {8'd0, a_data}, 16'h44);
        applyStimulus(1'b1, 1'b1, 8'h66, 1'b0, 1'b1);
        checkOutput("iso_66_in_ready", {15'd0, in_ready}, 16'd1);
        tick();
        checkOutput("iso_b_66_data", {8'd0, b_data}, 16'h66);
        checkOutput("iso_a_stalled", {15'd0, a_valid}, 16'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        checkOutput("bp_a_empty", {15'd0, a_valid}, 16'd0);
        checkOutput("bp_b_empty", {15'd0, b_valid}, 16'd0);

        // Pass-through streaming 0x01..0x08 on A
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 1'b0, WIDTH'(i), 1'b1, 1'b1);
            checkOutput("pt_in_ready", {15'd0, in_ready}, 16'd1);
            tick();
            checkOutput("pt_a_valid", {15'd0, a_valid}, 16'd1);
            checkOutput("pt_a_data", {8'd0, a_data}, 16'(i));
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        checkOutput("pt_a_end", {15'd0, a_valid}, 16'd0);

        // Asynchronous reset while A holds an undelivered word
        applyStimulus(1'b1, 1'b0, 8'h77, 1'b0, 1'b1);
        tick();
        checkOutput("ar_a_77_data", {8'd0, a_data}, 16'h77);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_a_valid_async", {15'd0, a_valid}, 16'd0);
        checkOutput("ar_a_data_async", {8'd0, a_data}, 16'd0);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        checkOutput("ar_77_not_delivered", {15'd0, a_valid}, 16'd0);

`ifdef STREAM_DEMUX_CNT_EN
        // Counter wrap: 17 transfers on A, 3 on B with CNT_W=4
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 1'b0, WIDTH'(i), 1'b1, 1'b1);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, WIDTH'(i), 1'b1, 1'b1);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        checkOutput("cnt_a_wrapped", {12'd0, cnt_a}, 16'd1);
        checkOutput("cnt_b", {12'd0, cnt_b}, 16'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
